// File: rtl/i2s_tx_tdm_channel.sv
// i2s_tx_tdm_channel
// TDM/DSP-mode serial transmitter: up to NUM_SLOTS slot words per frame on one
// data line, with per-slot masking, frame-sync offset and MSB/LSB-first order.
// Words arrive over a valid/ready handshake into a one-word holding register.
//
// Ports:
//   sck_i, rst_i        bit clock (posedge) and async active-high reset
//   ws_i                frame sync, frame starts on its rising edge
//   sd_o                registered serial data
//   fifo_data_i/valid_i/ready_o   slot word handshake from the TX FIFO
//   ready_to_send_o     first word buffered, waiting for frame sync
//   frame_active_o      inside a frame (offset or shifting)
//   underrun_o          pulse: enabled slot started with no word
//   frame_err_o         pulse: ws_i rose mid-frame
//   cfg_*               enable, slots-1, slot mask, bits-1, bit order, offset
module i2s_tx_tdm_channel #(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned MAX_BITS  = 32,
  parameter int unsigned OFFSET_W  = 9
) (
  input  logic                         sck_i,
  input  logic                         rst_i,
  input  logic                         ws_i,
  output logic                         sd_o,
  input  logic [MAX_BITS-1:0]          fifo_data_i,
  input  logic                         fifo_valid_i,
  output logic                         fifo_ready_o,
  output logic                         ready_to_send_o,
  output logic                         frame_active_o,
  output logic                         underrun_o,
  output logic                         frame_err_o,
  input  logic                         cfg_en_i,
  input  logic [$clog2(NUM_SLOTS)-1:0] cfg_num_slots_i,
  input  logic [NUM_SLOTS-1:0]         cfg_slot_mask_i,
  input  logic [$clog2(MAX_BITS)-1:0]  cfg_num_bits_i,
  input  logic                         cfg_lsb_first_i,
  input  logic [OFFSET_W-1:0]          cfg_offset_i
);

  localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
  localparam int unsigned BIT_W  = $clog2(MAX_BITS);

  typedef enum logic [2:0] {
    IDLE,
    PRELOAD,
    WAIT_FS,
    OFFSET,
    SHIFT
  } state_e;

  state_e state_q, state_d;

  logic                ws_q;
  logic                hold_valid;
  logic [MAX_BITS-1:0] hold_data;
  logic [MAX_BITS-1:0] shreg;
  logic [SLOT_W-1:0]   slot_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [OFFSET_W-1:0] off_cnt;

  logic                sync;
  logic                last_bit;
  logic                last_slot;
  logic                off_done;
  logic                clear;
  logic                start_slot;
  logic [SLOT_W-1:0]   start_idx;
  logic                go_offset;
  logic                frame_err_d;
  logic                slot_en;
  logic                hold_consumed;
  logic                fifo_xfer;
  logic                first_bit;
  logic                next_bit;

  assign sync      = ws_i & ~ws_q;
  // Range compares keep the counters terminating even if the configuration
  // is changed outside IDLE.
  assign last_bit  = (bit_cnt >= cfg_num_bits_i);
  assign last_slot = (slot_cnt >= cfg_num_slots_i);
  assign off_done  = (off_cnt >= (cfg_offset_i - 1'b1));
  assign clear     = ~cfg_en_i | (state_q == IDLE);

  assign slot_en       = cfg_slot_mask_i[start_idx];
  assign hold_consumed = start_slot & slot_en & hold_valid;
  assign fifo_ready_o  = cfg_en_i & (state_q != IDLE) & (~hold_valid | hold_consumed);
  assign fifo_xfer     = fifo_valid_i & fifo_ready_o;

  assign first_bit = cfg_lsb_first_i ? hold_data[0] : hold_data[cfg_num_bits_i];
  assign next_bit  = cfg_lsb_first_i ? shreg[0]     : shreg[cfg_num_bits_i];

  always_ff @(posedge sck_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    start_slot  = 1'b0;
    start_idx   = '0;
    go_offset   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = PRELOAD;
      end
      PRELOAD: begin
        if (hold_valid) begin
          state_d = WAIT_FS;
        end
      end
      WAIT_FS: begin
        if (sync) begin
          if (cfg_offset_i != '0) begin
            state_d   = OFFSET;
            go_offset = 1'b1;
          end else begin
            state_d    = SHIFT;
            start_slot = 1'b1;
          end
        end
      end
      OFFSET: begin
        frame_err_d = sync;
        if (off_done) begin
          state_d    = SHIFT;
          start_slot = 1'b1;
        end
      end
      SHIFT: begin
        frame_err_d = sync & ~(last_bit & last_slot);
        if (last_bit) begin
          if (!last_slot) begin
            start_slot = 1'b1;
            start_idx  = slot_cnt + 1'b1;
          end else if (sync) begin
            // Sync on the final bit edge: chain straight into the next frame.
            if (cfg_offset_i != '0) begin
              state_d   = OFFSET;
              go_offset = 1'b1;
            end else begin
              start_slot = 1'b1;
            end
          end else begin
            state_d = WAIT_FS;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (!cfg_en_i) begin
      state_d     = IDLE;
      start_slot  = 1'b0;
      go_offset   = 1'b0;
      frame_err_d = 1'b0;
    end
  end

  always_ff @(posedge sck_i or posedge rst_i) begin
    if (rst_i) begin
      ws_q <= 1'b0;
    end else begin
      ws_q <= ws_i;
    end
  end

  always_ff @(posedge sck_i or posedge rst_i) begin
    if (rst_i) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (clear) begin
      hold_valid <= 1'b0;
    end else if (fifo_xfer) begin
      hold_data  <= fifo_data_i;
      hold_valid <= 1'b1;
    end else if (hold_consumed) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge sck_i or posedge rst_i) begin
    if (rst_i) begin
      sd_o     <= 1'b0;
      shreg    <= '0;
      slot_cnt <= '0;
      bit_cnt  <= '0;
      off_cnt  <= '0;
    end else if (clear) begin
      sd_o     <= 1'b0;
      shreg    <= '0;
      slot_cnt <= '0;
      bit_cnt  <= '0;
      off_cnt  <= '0;
    end else if (start_slot) begin
      slot_cnt <= start_idx;
      bit_cnt  <= '0;
      // The first bit goes straight from the holding register to the pad, so
      // the shift register is loaded already advanced by one position.
      if (slot_en && hold_valid) begin
        sd_o  <= first_bit;
        shreg <= cfg_lsb_first_i ? (hold_data >> 1) : (hold_data << 1);
      end else begin
        sd_o  <= 1'b0;
        shreg <= '0;
      end
    end else if ((state_q == SHIFT) && !last_bit) begin
      bit_cnt <= bit_cnt + 1'b1;
      sd_o    <= next_bit;
      shreg   <= cfg_lsb_first_i ? (shreg >> 1) : (shreg << 1);
    end else begin
      sd_o <= 1'b0;
      if (go_offset) begin
        off_cnt <= '0;
      end else if (state_q == OFFSET) begin
        off_cnt <= off_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge sck_i or posedge rst_i) begin
    if (rst_i) begin
      underrun_o      <= 1'b0;
      frame_err_o     <= 1'b0;
      frame_active_o  <= 1'b0;
      ready_to_send_o <= 1'b0;
    end else begin
      underrun_o      <= start_slot & slot_en & ~hold_valid;
      frame_err_o     <= frame_err_d;
      frame_active_o  <= (state_d == OFFSET) || (state_d == SHIFT);
      ready_to_send_o <= (state_d == WAIT_FS);
    end
  end

endmodule

// File: tb/tb_i2s_tx_tdm_channel.sv
module tb_i2s_tx_tdm_channel;

  logic        sck_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ws_i = 1'b0;
  logic        sd_o;
  logic [31:0] fifo_data_i;
  logic        fifo_valid_i;
  logic        fifo_ready_o;
  logic        ready_to_send_o;
  logic        frame_active_o;
  logic        underrun_o;
  logic        frame_err_o;
  logic        cfg_en_i = 1'b0;
  logic [2:0]  cfg_num_slots_i = '0;
  logic [7:0]  cfg_slot_mask_i = '0;
  logic [4:0]  cfg_num_bits_i = '0;
  logic        cfg_lsb_first_i = 1'b0;
  logic [8:0]  cfg_offset_i = '0;

  i2s_tx_tdm_channel #(
    .NUM_SLOTS (8),
    .MAX_BITS  (32),
    .OFFSET_W  (9)
  ) dut (
    .sck_i           (sck_i),
    .rst_i           (rst_i),
    .ws_i            (ws_i),
    .sd_o            (sd_o),
    .fifo_data_i     (fifo_data_i),
    .fifo_valid_i    (fifo_valid_i),
    .fifo_ready_o    (fifo_ready_o),
    .ready_to_send_o (ready_to_send_o),
    .frame_active_o  (frame_active_o),
    .underrun_o      (underrun_o),
    .frame_err_o     (frame_err_o),
    .cfg_en_i        (cfg_en_i),
    .cfg_num_slots_i (cfg_num_slots_i),
    .cfg_slot_mask_i (cfg_slot_mask_i),
    .cfg_num_bits_i  (cfg_num_bits_i),
    .cfg_lsb_first_i (cfg_lsb_first_i),
    .cfg_offset_i    (cfg_offset_i)
  );

  always #5 sck_i = ~sck_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // FIFO source: words stay visible until a handshake is seen.
  logic [31:0] fifo_mem [0:63];
  int fifo_wr = 0;
  int fifo_rd = 0;
  int hs_cnt  = 0;
  assign fifo_valid_i = (fifo_rd < fifo_wr);
  assign fifo_data_i  = fifo_mem[fifo_rd];

  always @(negedge sck_i) begin
    if (fifo_valid_i && fifo_ready_o) begin
      @(posedge sck_i);
      #1;
      fifo_rd++;
      hs_cnt++;
    end
  end

  // Scoreboard: words the model expects to find, and the expected
  // {frame_active, sd, underrun, frame_err} per bit clock.
  logic [31:0] mq [$];
  logic [3:0]  exp_q [$];
  int   c_ns, c_nb, c_off;
  logic [7:0] c_mask;
  bit   c_lsb;

  task automatic push_word(input logic [31:0] w);
    fifo_mem[fifo_wr] = w;
    fifo_wr++;
    mq.push_back(w);
  endtask

  task automatic configure(input int ns, input int nb, input logic [7:0] mask,
                           input bit lsb, input int off);
    @(posedge sck_i); #2 cfg_en_i = 1'b0;
    @(posedge sck_i); #2;
    c_ns = ns; c_nb = nb; c_mask = mask; c_lsb = lsb; c_off = off;
    cfg_num_slots_i = 3'(ns);
    cfg_num_bits_i  = 5'(nb);
    cfg_slot_mask_i = mask;
    cfg_lsb_first_i = lsb;
    cfg_offset_i    = 9'(off);
    fifo_rd = fifo_wr;
    mq.delete();
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready_to_send_o && n < 50) begin
      @(negedge sck_i);
      n++;
    end
    check_eq({tag, " ready_to_send"}, 32'(ready_to_send_o), 32'd1);
  endtask

  task automatic build_frame(input int err_at, input bit b2b_out);
    int pos = 0;
    for (int i = 0; i < c_off; i++) begin
      exp_q.push_back({1'b1, 1'b0, 1'b0, (pos == err_at)});
      pos++;
    end
    for (int s = 0; s <= c_ns; s++) begin
      logic [31:0] w;
      logic ur;
      w = '0;
      ur = 1'b0;
      if (c_mask[s]) begin
        if (mq.size() > 0) w = mq.pop_front();
        else ur = 1'b1;
      end
      for (int b = 0; b <= c_nb; b++) begin
        int idx;
        idx = c_lsb ? b : (c_nb - b);
        exp_q.push_back({1'b1, w[idx], (ur && (b == 0)), (pos == err_at)});
        pos++;
      end
    end
    if (!b2b_out) exp_q.push_back(4'b0000);
  endtask

  task automatic run_frame(input string tag, input int err_at, input bit b2b_in, input bit b2b_out);
    int n;
    build_frame(err_at, b2b_out);
    n = exp_q.size();
    if (!b2b_in) begin
      @(posedge sck_i); #2 ws_i = 1'b1;
    end
    for (int i = 0; i < n; i++) begin
      @(posedge sck_i); #2;
      if (i == 0) ws_i = 1'b0;
      if (err_at >= 2 && i == err_at - 1) ws_i = 1'b1;
      if (err_at >= 2 && i == err_at) ws_i = 1'b0;
      if (b2b_out && i == n - 1) ws_i = 1'b1;
      @(negedge sck_i);
      check_eq($sformatf("%s bit%0d", tag, i),
               32'({frame_active_o, sd_o, underrun_o, frame_err_o}), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;

    #12;
    check_eq("reset outputs",
             32'({sd_o, fifo_ready_o, ready_to_send_o, frame_active_o, underrun_o, frame_err_o}), 32'd0);
    @(posedge sck_i); #2 rst_i = 1'b0;

    // Basic 4 x 8 MSB-first.
    configure(3, 7, 8'hFF, 0, 0);
    hs0 = hs_cnt;
    push_word(32'hA5); push_word(32'h3C); push_word(32'hFF); push_word(32'h01);
    cfg_en_i = 1'b1;
    wait_ready("basic");
    run_frame("basic", -1, 0, 0);
    check_eq("basic handshakes", 32'(hs_cnt - hs0), 32'd4);

    // Offset 3, 16-bit, LSB-first.
    configure(1, 15, 8'hFF, 1, 3);
    push_word(32'h8001); push_word(32'h00F0);
    cfg_en_i = 1'b1;
    wait_ready("offset");
    run_frame("offset", -1, 0, 0);

    // Slot masking.
    configure(3, 7, 8'h05, 0, 0);
    hs0 = hs_cnt;
    push_word(32'h11); push_word(32'h22);
    cfg_en_i = 1'b1;
    wait_ready("mask");
    run_frame("mask", -1, 0, 0);
    check_eq("mask handshakes", 32'(hs_cnt - hs0), 32'd2);

    // Underrun then recovery.
    configure(1, 7, 8'hFF, 0, 0);
    push_word(32'h5A);
    cfg_en_i = 1'b1;
    wait_ready("underrun");
    run_frame("underrun", -1, 0, 0);
    @(posedge sck_i); #2;
    push_word(32'hC3); push_word(32'h96);
    run_frame("recover", -1, 0, 0);

    // One-bit slots with a FIFO that never runs dry.
    configure(3, 0, 8'hFF, 0, 0);
    push_word(32'h1); push_word(32'h0); push_word(32'h1); push_word(32'h1);
    cfg_en_i = 1'b1;
    wait_ready("onebit");
    run_frame("onebit", -1, 0, 0);

    // Mid-frame sync error followed by a back-to-back frame.
    configure(3, 7, 8'hFF, 0, 0);
    push_word(32'h81); push_word(32'h42); push_word(32'h24); push_word(32'h18);
    push_word(32'hF0); push_word(32'h0F); push_word(32'hCC); push_word(32'h33);
    cfg_en_i = 1'b1;
    wait_ready("syncerr");
    run_frame("syncerr", 5, 0, 1);
    run_frame("b2b", -1, 1, 0);

    // Disable mid-slot.
    configure(1, 7, 8'hFF, 0, 0);
    push_word(32'hFF); push_word(32'hFF);
    cfg_en_i = 1'b1;
    wait_ready("disable");
    @(posedge sck_i); #2 ws_i = 1'b1;
    @(posedge sck_i); #2 ws_i = 1'b0;
    @(posedge sck_i); #2;
    @(posedge sck_i); #2;
    @(negedge sck_i);
    check_eq("disable mid-slot", 32'({frame_active_o, sd_o}), 32'b11);
    @(posedge sck_i); #2 cfg_en_i = 1'b0;
    @(negedge sck_i);
    check_eq("disable before edge", 32'({frame_active_o, sd_o}), 32'b11);
    @(negedge sck_i);
    check_eq("disable after edge",
             32'({frame_active_o, sd_o, ready_to_send_o, fifo_ready_o}), 32'd0);

    // Asynchronous reset mid-frame, then clean restart.
    configure(1, 7, 8'hFF, 0, 0);
    push_word(32'hFF); push_word(32'hFF);
    cfg_en_i = 1'b1;
    wait_ready("reset");
    @(posedge sck_i); #2 ws_i = 1'b1;
    @(posedge sck_i); #2 ws_i = 1'b0;
    @(posedge sck_i); #2;
    @(negedge sck_i);
    check_eq("reset mid-frame", 32'({frame_active_o, sd_o}), 32'b11);
    @(posedge sck_i); #2 rst_i = 1'b1;
    #1;
    check_eq("reset async clear",
             32'({sd_o, fifo_ready_o, ready_to_send_o, frame_active_o, underrun_o, frame_err_o}), 32'd0);
    @(posedge sck_i); #2 rst_i = 1'b0;
    fifo_rd = fifo_wr;
    mq.delete();
    push_word(32'h3C); push_word(32'h81);
    @(negedge sck_i);
    check_eq("restart not ready", 32'(ready_to_send_o), 32'd0);
    wait_ready("restart");
    run_frame("restart", -1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
